// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the iterative CORDIC rotator.
//   WIDTH  - default data/angle word width
//   ITER   - default number of micro-rotations
//   K_Q6   - CORDIC gain compensation 0.60725 in Q1.6 (round(0.60725*64))
//   ST_*   - FSM state encodings, state_t is the state register type
//   atan_lut(i) - round(atan(2^-i)*128/pi) in binary-angle LSBs
package cordic_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int K_Q6  = 39;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ROT  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int atan_lut(input int i);
    case (i)
      0:       atan_lut = 32;
      1:       atan_lut = 19;
      2:       atan_lut = 10;
      3:       atan_lut = 5;
      4:       atan_lut = 3;
      5:       atan_lut = 1;
      6:       atan_lut = 1;
      default: atan_lut = 0;  // atan(2^-i) rounds to zero from i = 7 onward
    endcase
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational arctangent table for the micro-rotations.
//   i    - iteration index
//   atan - atan[i] in binary-angle LSBs, sign-extended to WIDTH+2 bits
module cordic_atan_rom #(
  parameter int WIDTH = cordic_pkg::WIDTH,
  parameter int IW    = 4
) (
  input  logic [IW-1:0]           i,
  output logic signed [WIDTH+1:0] atan
);
  import cordic_pkg::*;

  always_comb begin
    atan = (WIDTH+2)'(atan_lut(int'(i)));
  end

endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative rotation-mode CORDIC, one micro-rotation per clock.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request, sampled only while idle
//   angle_in   - signed binary angle (quarter turn = 2^(WIDTH-2))
//   busy       - high while rotating or presenting a result
//   out_valid  - one-cycle pulse when cos_out/sin_out/neg_flag are updated
//   cos_out    - Q1.6 cosine, before quadrant correction
//   sin_out    - Q1.6 sine, before quadrant correction
//   neg_flag   - downstream converter must negate both cos_out and sin_out
//   state_dbg  - current FSM state (ST_IDLE/ST_ROT/ST_DONE)
//
// Handshake: start is a request taken only in IDLE; a start seen while busy
// is dropped, never queued. out_valid is a pulse with no ready; the outputs
// stay stable until the next pulse.
module cordic_iter #(
  parameter int WIDTH = cordic_pkg::WIDTH,
  parameter int ITER  = cordic_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] angle_in,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out,
  output logic             neg_flag,
  output logic [1:0]       state_dbg
);
  import cordic_pkg::*;

  localparam int XW = WIDTH + 2;
  localparam int IW = $clog2(ITER + 1);
  localparam logic signed [WIDTH:0]  QTR  = (WIDTH+1)'(1 << (WIDTH - 2));
  localparam logic signed [XW-1:0]   OMAX = XW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0]   OMIN = XW'(-(1 << (WIDTH - 1)));

  state_t                state;
  logic [IW-1:0]         iter;
  logic signed [XW-1:0]  x, y, z;
  logic                  neg_pend;

  // Pre-rotation: angles beyond +/-90 deg are turned by 180 deg so the
  // iterations only ever have to cover the right half-plane.
  logic signed [WIDTH:0]  ang_ext, ang_abs;
  logic                   wrap;
  logic [WIDTH-1:0]       ang_rot;
  logic signed [XW-1:0]   z0;

  always_comb begin
    ang_ext = {angle_in[WIDTH-1], angle_in};
    ang_abs = ang_ext[WIDTH] ? -ang_ext : ang_ext;
    wrap    = ang_abs > QTR;
    ang_rot = wrap ? angle_in + {1'b1, {(WIDTH-1){1'b0}}} : angle_in;
    z0      = XW'($signed(ang_rot));
  end

  logic signed [XW-1:0] atan_i;

  cordic_atan_rom #(.WIDTH(WIDTH), .IW(IW)) u_atan_rom (
    .i    (iter),
    .atan (atan_i)
  );

  // One micro-rotation; both shifts use the pre-update x and y.
  logic signed [XW-1:0] x_sh, y_sh, x_nx, y_nx, z_nx;
  logic                 last;

  always_comb begin
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    if (z[XW-1]) begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + atan_i;
    end else begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - atan_i;
    end
    last = (iter == IW'(ITER - 1));
  end

  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > OMAX)      sat = OMAX[WIDTH-1:0];
    else if (v < OMIN) sat = OMIN[WIDTH-1:0];
    else               sat = v[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      iter     <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      neg_pend <= 1'b0;
      cos_out  <= '0;
      sin_out  <= '0;
      neg_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ROT;
            iter     <= '0;
            x        <= XW'(K_Q6);
            y        <= '0;
            z        <= z0;
            neg_pend <= wrap;
          end
        end
        ST_ROT: begin
          x    <= x_nx;
          y    <= y_nx;
          z    <= z_nx;
          iter <= iter + 1'b1;
          if (last) begin
            state    <= ST_DONE;
            cos_out  <= sat(x_nx);
            sin_out  <= sat(y_nx);
            neg_flag <= neg_pend;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_cordic_iter.sv
module tb_cordic_iter;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] angle_in;
  logic             busy, out_valid, neg_flag;
  logic [WIDTH-1:0] cos_out, sin_out;
  logic [1:0]       state_dbg;

  cordic_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .angle_in  (angle_in),
    .busy      (busy),
    .out_valid (out_valid),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .neg_flag  (neg_flag),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*WIDTH:0] exp_q[$];   // {neg, sin, cos}

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer CORDIC straight from the rules: half-turn pre-rotation for
  // |angle| > quarter turn, gain-compensated start vector, ITER rotations,
  // final clamp to the output range.
  function automatic logic [2*WIDTH:0] model(input logic [WIDTH-1:0] ang);
    int tab[8] = '{32, 19, 10, 5, 3, 1, 1, 0};
    int a, z, x, y, xs, ys, c, s;
    bit neg;
    a   = $signed(ang);
    neg = (a > 64) || (a < -64);
    z   = neg ? ((a > 0) ? a - 128 : a + 128) : a;
    x   = 39;
    y   = 0;
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin x = x - ys; y = y + xs; z = z - tab[i]; end
      else        begin x = x + ys; y = y - xs; z = z + tab[i]; end
    end
    c = (x > 127) ? 127 : (x < -128) ? -128 : x;
    s = (y > 127) ? 127 : (y < -128) ? -128 : y;
    model = {neg, s[7:0], c[7:0]};
  endfunction

  // ---------------- driver ----------------
  // Issues one start (called away from the clock edge), optionally pulses a
  // second start with another angle at edge glitch_at, and watches the op
  // through to idle. lat counts edges including the one that samples start.
  task automatic do_op(input logic [WIDTH-1:0] ang, input int glitch_at,
                       input logic [WIDTH-1:0] g_ang,
                       output logic [2*WIDTH:0] got, output int lat,
                       output int busy_cnt, output int pulses);
    start    = 1'b1;
    angle_in = ang;
    lat      = -1;
    busy_cnt = 0;
    pulses   = 0;
    got      = '0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
      if (e == glitch_at) begin start = 1'b1; angle_in = g_ang; end
      if (e == glitch_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = e;
          got = {neg_flag, sin_out, cos_out};
        end
      end
      if (!busy && lat >= 0) break;
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] ang;
    int               ecos;
    int               esin;
    int               eneg;
  } vec_t;

  vec_t             tab[6];
  logic [2*WIDTH:0] got, exp_v, hold_v;
  int               lat, bcnt, pulses, cnt;
  logic [WIDTH-1:0] corners[7] = '{8'h40, 8'h41, 8'hBF, 8'hC0, 8'h7F, 8'h80, 8'hC1};
  logic [WIDTH-1:0] ang;

  initial begin
    tab[0] = '{8'h00,  64,   0, 0};
    tab[1] = '{8'h20,  45,  45, 0};
    tab[2] = '{8'h40,   0,  64, 0};
    tab[3] = '{8'hC0,   0, -64, 0};
    tab[4] = '{8'h80,  64,   0, 1};
    tab[5] = '{8'h60,  45, -45, 1};

    rst_n    = 1'b0;
    start    = 1'b0;
    angle_in = '0;
    #12;
    check("rst_cos",   int'(cos_out),   0, 0);
    check("rst_sin",   int'(sin_out),   0, 0);
    check("rst_neg",   int'(neg_flag),  0, 0);
    check("rst_valid", int'(out_valid), 0, 0);
    check("rst_busy",  int'(busy),      0, 0);
    #10 rst_n = 1'b1;   // t=22, between edges

    // Directed vectors with tolerance, plus latency / busy / pulse / hold.
    for (int k = 0; k < 6; k++) begin
      do_op(tab[k].ang, -1, '0, got, lat, bcnt, pulses);
      check($sformatf("tab%0d_lat", k),   lat, ITER + 1, 0);
      check($sformatf("tab%0d_busy", k),  bcnt, ITER + 1, 0);
      check($sformatf("tab%0d_pulse", k), pulses, 1, 0);
      check($sformatf("tab%0d_cos", k), int'($signed(got[7:0])),  tab[k].ecos, 2);
      check($sformatf("tab%0d_sin", k), int'($signed(got[15:8])), tab[k].esin, 2);
      check($sformatf("tab%0d_neg", k), int'(got[16]), tab[k].eneg, 0);
      @(posedge clk); #1;
      hold_v = {neg_flag, sin_out, cos_out};
      check($sformatf("tab%0d_hold", k), int'(hold_v), int'(got), 0);
    end

    // Corner angles around the pre-rotation boundary, then random angles,
    // all against the reference model exactly.
    for (int k = 0; k < 47; k++) begin
      ang = (k < 7) ? corners[k] : WIDTH'($urandom_range(0, 255));
      exp_q.push_back(model(ang));
      do_op(ang, -1, '0, got, lat, bcnt, pulses);
      exp_v = exp_q.pop_front();
      check($sformatf("rnd%0d_lat a=%02h", k, ang), lat, ITER + 1, 0);
      check($sformatf("rnd%0d_res a=%02h", k, ang), int'(got), int'(exp_v), 0);
    end

    // Start pulsed mid-rotation with another angle must be ignored.
    exp_q.push_back(model(8'h20));
    do_op(8'h20, 3, 8'hD0, got, lat, bcnt, pulses);
    exp_v = exp_q.pop_front();
    check("glitch_res",   int'(got), int'(exp_v), 0);
    check("glitch_busy",  bcnt, ITER + 1, 0);
    check("glitch_lat",   lat, ITER + 1, 0);
    check("glitch_pulse", pulses, 1, 0);

    // Back-to-back: start held from the DONE cycle is taken in the next IDLE.
    start = 1'b1; angle_in = 8'h10;
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
      if (cnt == 1) start = 1'b0;
    end while (!out_valid && cnt < 20);
    check("b2b_first_valid", int'(out_valid), 1, 0);
    start = 1'b1; angle_in = 8'hE0;
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
      if (cnt == 2) start = 1'b0;
    end while (!out_valid && cnt < 20);
    check("b2b_period", cnt, ITER + 2, 0);
    check("b2b_res", int'({neg_flag, sin_out, cos_out}), int'(model(8'hE0)), 0);
    @(posedge clk); #1;

    // Reset during iteration 4 abandons the op and clears outputs at once.
    start = 1'b1; angle_in = 8'h20;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_cos",   int'(cos_out),   0, 0);
    check("mid_rst_sin",   int'(sin_out),   0, 0);
    check("mid_rst_neg",   int'(neg_flag),  0, 0);
    check("mid_rst_valid", int'(out_valid), 0, 0);
    check("mid_rst_busy",  int'(busy),      0, 0);
    pulses = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("mid_rst_no_valid", pulses, 0, 0);
    rst_n = 1'b1;
    exp_q.push_back(model(8'h30));
    do_op(8'h30, -1, '0, got, lat, bcnt, pulses);
    exp_v = exp_q.pop_front();
    check("post_rst_lat", lat, ITER + 1, 0);
    check("post_rst_res", int'(got), int'(exp_v), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
